// File: rtl/frame_stream_mem_writer.sv
// Captures one Avalon-ST frame of 32-bit beats and writes it as 128-bit words
// through an Avalon-MM write port, with partial-word byte enables and overflow.
module frame_stream_mem_writer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         word_limit,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [15:0]         words_written,
  input  logic [31:0]         snk_data,
  input  logic                snk_valid,
  input  logic                snk_sop,
  input  logic                snk_eop,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [15:0]         avm_byteenable,
  input  logic                avm_waitrequest,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_PACK  = 3'd2,
    S_WRITE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_limit;
  logic [2:0]          r_lane;
  logic [DATA_W-1:0]   r_data;
  logic                r_eop_word;
  logic [15:0]         r_words;
  logic                r_overflow;
  logic                w_accept;
  logic                w_wr_done;
  logic                w_at_limit;

  // Handshakes: a beat transfers on any edge where snk_valid && snk_ready; a
  // word commits on any edge where avm_write && !avm_waitrequest, and address,
  // data and byte enables hold unchanged until that edge.
  assign snk_ready  = (r_state == S_ARMED) || (r_state == S_PACK) || (r_state == S_DRAIN);
  assign w_accept   = snk_valid && snk_ready;
  assign w_wr_done  = (r_state == S_WRITE) && !avm_waitrequest;
  assign w_at_limit = (r_limit != 16'd0) && ((r_words + 16'd1) == r_limit);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ARMED;
      S_ARMED: if (w_accept && snk_sop) w_next = snk_eop ? S_WRITE : S_PACK;
      S_PACK:  if (w_accept && (snk_eop || r_lane == 3'd3)) w_next = S_WRITE;
      S_WRITE: begin
        if (w_wr_done) begin
          if (r_eop_word)      w_next = S_DONE;
          else if (w_at_limit) w_next = S_DRAIN;
          else                 w_next = S_PACK;
        end
      end
      S_DRAIN: if (w_accept && snk_eop) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_limit    <= '0;
      r_lane     <= '0;
      r_data     <= '0;
      r_eop_word <= 1'b0;
      r_words    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_limit    <= word_limit;
            r_lane     <= '0;
            r_data     <= '0;
            r_eop_word <= 1'b0;
            r_words    <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_accept && snk_sop) begin
            r_data     <= {{(DATA_W-32){1'b0}}, snk_data};
            r_lane     <= 3'd1;
            r_eop_word <= snk_eop;
          end
        end
        S_PACK: begin
          if (w_accept) begin
            r_data[32*r_lane[1:0] +: 32] <= snk_data;
            r_lane                       <= r_lane + 3'd1;
            r_eop_word                   <= snk_eop;
          end
        end
        S_WRITE: begin
          if (w_wr_done) begin
            r_addr  <= r_addr + 1'b1;
            r_words <= r_words + 16'd1;
            r_lane  <= '0;
            r_data  <= '0;
          end
        end
        S_DRAIN: if (w_accept) r_overflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // r_lane holds the number of filled lanes while a word is being written.
  assign avm_byteenable = (r_state == S_WRITE) ?
                          {{4{r_lane > 3'd3}}, {4{r_lane > 3'd2}},
                           {4{r_lane > 3'd1}}, {4{r_lane != 3'd0}}} : 16'h0000;
  assign avm_write      = (r_state == S_WRITE);
  assign avm_address    = r_addr;
  assign avm_writedata  = r_data;
  assign busy           = (r_state == S_ARMED) || (r_state == S_PACK) ||
                          (r_state == S_WRITE) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign overflow       = r_overflow;
  assign words_written  = r_words;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_frame_stream_mem_writer.sv
// Directed bench for frame_stream_mem_writer: hand-computed words go into an
// expected queue that a commit monitor drains; per-frame status is checked.
module tb_frame_stream_mem_writer;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       word_limit = '0;
  logic              busy, done, overflow;
  logic [15:0]       words_written;
  logic [31:0]       snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_sop = 1'b0;
  logic              snk_eop = 1'b0;
  logic              snk_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [15:0]       avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [2:0]        dbg_state;

  frame_stream_mem_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_limit(word_limit), .busy(busy), .done(done), .overflow(overflow),
    .words_written(words_written), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int wr_high_cnt = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic [15:0]       exp_be_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [15:0] be);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    exp_be_q.push_back(be);
  endtask

  // scoreboard: every committed write must match the head of the expected queue
  always @(negedge clk) begin
    if (avm_write) wr_high_cnt++;
    if (done) done_cnt++;
    if (avm_write && !avm_waitrequest) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", {113'd0, avm_address}, 128'd0);
      end else begin
        check("wr_addr", {113'd0, avm_address}, {113'd0, exp_addr_q.pop_front()});
        check("wr_data", avm_writedata, exp_data_q.pop_front());
        check("wr_be", {112'd0, avm_byteenable}, {112'd0, exp_be_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [15:0] lim);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_limit = lim;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
    int n;
    n = 0;
    snk_data = d; snk_valid = 1'b1; snk_sop = sop; snk_eop = eop;
    @(negedge clk);
    while (!snk_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!snk_ready) check("beat_timeout", {127'd0, snk_ready}, 128'd1);
    @(posedge clk); #1;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] first, input int len);
    for (int i = 0; i < len; i++)
      send_beat(first + 32'(i), i == 0, i == len - 1);
  endtask

  task automatic finish_frame(input string tag, input logic [15:0] exp_words,
                              input logic exp_ovf);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != 3'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {125'd0, dbg_state}, 128'd0);
    check({tag, "_words"}, {112'd0, words_written}, {112'd0, exp_words});
    check({tag, "_ovf"}, {127'd0, overflow}, {127'd0, exp_ovf});
    check({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
    check({tag, "_pending"}, 128'(exp_addr_q.size()), 128'd0);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    done_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {127'd0, snk_ready}, 128'd0);
    check("rst_write", {127'd0, avm_write}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_state", {125'd0, dbg_state}, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 8-beat frame, unlimited
    push_exp(15'h0100, {32'h3, 32'h2, 32'h1, 32'h0}, 16'hFFFF);
    push_exp(15'h0101, {32'h7, 32'h6, 32'h5, 32'h4}, 16'hFFFF);
    do_start(15'h0100, 16'd0);
    check("armed_ready", {127'd0, snk_ready}, 128'd1);
    send_frame(32'h0, 8);
    finish_frame("f8", 16'd2, 1'b0);

    // 6-beat frame: partial second word
    push_exp(15'h0200, {32'h13, 32'h12, 32'h11, 32'h10}, 16'hFFFF);
    push_exp(15'h0201, {32'h0, 32'h0, 32'h15, 32'h14}, 16'h00FF);
    do_start(15'h0200, 16'd0);
    send_frame(32'h10, 6);
    finish_frame("f6", 16'd2, 1'b0);

    // single sop+eop beat
    push_exp(15'h0300, {96'h0, 32'hDEADBEEF}, 16'h000F);
    do_start(15'h0300, 16'd0);
    send_beat(32'hDEADBEEF, 1'b1, 1'b1);
    finish_frame("f1", 16'd1, 1'b0);

    // waitrequest high for 3 cycles on the write
    avm_waitrequest = 1'b1;
    wr_high_cnt = 0;
    push_exp(15'h0400, {32'h53, 32'h52, 32'h51, 32'h50}, 16'hFFFF);
    do_start(15'h0400, 16'd0);
    send_frame(32'h50, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_write", {127'd0, avm_write}, 128'd1);
      check("wait_ready", {127'd0, snk_ready}, 128'd0);
      check("wait_addr", {113'd0, avm_address}, {113'd0, 15'h0400});
      check("wait_data", avm_writedata, {32'h53, 32'h52, 32'h51, 32'h50});
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    finish_frame("fwait", 16'd1, 1'b0);
    check("wait_write_cycles", 128'(wr_high_cnt), 128'd4);

    // limit=1 with a 12-beat frame: overflow and drain
    push_exp(15'h0500, {32'h23, 32'h22, 32'h21, 32'h20}, 16'hFFFF);
    do_start(15'h0500, 16'd1);
    send_frame(32'h20, 12);
    finish_frame("fovf", 16'd1, 1'b1);

    // address wrap, stray beats before sop, start ignored mid-frame
    push_exp(15'h7FFF, {32'h33, 32'h32, 32'h31, 32'h30}, 16'hFFFF);
    push_exp(15'h0000, {32'h37, 32'h36, 32'h35, 32'h34}, 16'hFFFF);
    do_start(15'h7FFF, 16'd0);
    for (int i = 0; i < 3; i++) send_beat(32'hBAD0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(32'h30 + 32'(i), i == 0, 1'b0);
    do_start(15'h1234, 16'd1);
    for (int i = 4; i < 8; i++) send_beat(32'h30 + 32'(i), 1'b0, i == 7);
    finish_frame("fwrap", 16'd2, 1'b0);

    // reset with two beats buffered
    do_start(15'h0600, 16'd0);
    send_beat(32'h60, 1'b1, 1'b0);
    send_beat(32'h61, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst2_ready", {127'd0, snk_ready}, 128'd0);
    check("rst2_write", {127'd0, avm_write}, 128'd0);
    check("rst2_addr", {113'd0, avm_address}, 128'd0);
    check("rst2_data", avm_writedata, 128'd0);
    check("rst2_be", {112'd0, avm_byteenable}, 128'd0);
    check("rst2_busy", {127'd0, busy}, 128'd0);
    check("rst2_done", {127'd0, done}, 128'd0);
    check("rst2_ovf", {127'd0, overflow}, 128'd0);
    check("rst2_words", {112'd0, words_written}, 128'd0);
    check("rst2_state", {125'd0, dbg_state}, 128'd0);
    repeat (3) @(posedge clk);
    push_exp(15'h0700, {32'h43, 32'h42, 32'h41, 32'h40}, 16'hFFFF);
    do_start(15'h0700, 16'd0);
    send_frame(32'h40, 4);
    finish_frame("fpost", 16'd1, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
